countdown4: RTL and testbench

COUNTDOWN4 -- requirements
Module: countdown4

---
 rtl/countdown4.sv | 71 +++++++
 tb/tb_countdown4.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown4.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle underflow pulse.
// Define COUNTDOWN4_AUTO_RELOAD_EN to reload on terminal count instead of stopping in DONE.
module countdown4 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             underflow
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             underflow_q, underflow_d;
   logic             terminal;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      reload_d    = reload_q;
      underflow_d = 1'b0;
      terminal    = (state_q == StRun) && enable && (count_q == One);
      if (load) begin
         count_d  = load_value;
         reload_d = load_value;
         state_d  = (load_value != '0) ? StRun : StIdle;
      end else if (terminal) begin
         underflow_d = 1'b1;
`ifdef COUNTDOWN4_AUTO_RELOAD_EN
         count_d = reload_q;
`else
         count_d = '0;
         state_d = StDone;
`endif
      end else if ((state_q == StRun) && enable && (count_q > One)) begin
         count_d = count_q - One;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         reload_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         reload_q    <= reload_d;
         underflow_q <= underflow_d;
      end
   end

   assign count     = count_q;
   assign zero      = (count_q == '0);
   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign underflow = underflow_q;

endmodule

// File: tb/tb_countdown4.sv
// Self-checking bench for countdown4: directed scenarios plus randomized traffic
// compared against a cycle-level reference model.
module tb_countdown4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic [3:0] count;
   logic       zero, busy, done, underflow;

   int checks = 0;
   int failures = 0;

   // Reference model: mode 0 = idle, 1 = run, 2 = done.
   int m_count = 0;
   int m_reload = 0;
   int m_mode = 0;
   bit m_uf = 1'b0;

   countdown4 #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .zero       (zero),
      .busy       (busy),
      .done       (done),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_vec();
      logic [3:0] c;
      c = 4'(m_count);
      return {c, m_count == 0, m_mode == 1, m_mode == 2, m_uf};
   endfunction

   function automatic logic [7:0] act_vec();
      return {count, zero, busy, done, underflow};
   endfunction

   task automatic model_reset();
      m_count = 0; m_reload = 0; m_mode = 0; m_uf = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit ld, input int lv);
      m_uf = 1'b0;
      if (ld) begin
         m_count = lv; m_reload = lv;
         m_mode = (lv != 0) ? 1 : 0;
      end else if (m_mode == 1 && en) begin
         if (m_count > 1) m_count = m_count - 1;
         else if (m_count == 1) begin
            m_uf = 1'b1;
`ifdef COUNTDOWN4_AUTO_RELOAD_EN
            m_count = m_reload;
`else
            m_count = 0; m_mode = 2;
`endif
         end
      end
   endtask

   task automatic drive_cycle(input bit en, input bit ld, input int lv);
      @(negedge clk);
      enable = en; load = ld; load_value = 4'(lv);
      @(posedge clk);
      model_step(en, ld, lv);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] a;
      // power-on reset, checked before any clock edge
      #3;
      a = act_vec(); checks++;
      if (a !== 8'b0000_1000) begin
         failures++; $display("FAIL reset_initial: actual=%b required=%b", a, 8'b0000_1000);
      end
      @(negedge clk); reset_n = 1'b1;
      drive_cycle(1'b0, 1'b1, 7);
      drive_cycle(1'b1, 1'b0, 0);
      // asynchronous assertion mid-RUN, between edges
      @(negedge clk); #2; reset_n = 1'b0; model_reset(); #1;
      a = act_vec(); checks++;
      if (a !== exp_vec()) begin
         failures++; $display("FAIL reset_async: actual=%b required=%b", a, exp_vec());
      end
      enable = 1'b1;
      @(posedge clk); #1;
      a = act_vec(); checks++;
      if (a !== exp_vec()) begin
         failures++; $display("FAIL reset_hold: actual=%b required=%b", a, exp_vec());
      end
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b1, 1'b0, 0);
         a = act_vec(); checks++;
         if (a !== exp_vec()) begin
            failures++; $display("FAIL reset_release_idle[%0d]: actual=%b required=%b", i, a, exp_vec());
         end
      end
   endtask

   task automatic test_count_to_zero();
      logic [7:0] a;
      int ufs = 0;
      drive_cycle(1'b0, 1'b1, 3);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, 1'b0, 0);
         if (underflow) ufs++;
         a = act_vec(); checks++;
         if (a !== exp_vec()) begin
            failures++; $display("FAIL count_to_zero[%0d]: actual=%b required=%b", i, a, exp_vec());
         end
      end
`ifndef COUNTDOWN4_AUTO_RELOAD_EN
      checks++;
      if (ufs != 1 || count !== 4'd0 || done !== 1'b1) begin
         failures++; $display("FAIL count_to_zero_end: actual ufs=%0d count=%0d done=%b required ufs=1 count=0 done=1",
                              ufs, count, done);
      end
`endif
   endtask

   task automatic test_enable_gating();
      logic [7:0] a;
      logic [3:0] exp_seq [4];
      exp_seq = '{4'd4, 4'd4, 4'd3, 4'd3};
      drive_cycle(1'b0, 1'b1, 5);
      for (int i = 0; i < 4; i++) begin
         drive_cycle((i % 2) == 0, 1'b0, 0);
         a = act_vec(); checks++;
         if (a !== exp_vec() || count !== exp_seq[i] || busy !== 1'b1 || underflow !== 1'b0) begin
            failures++; $display("FAIL enable_gating[%0d]: actual=%b required=%b (count %0d)",
                                 i, a, exp_vec(), exp_seq[i]);
         end
      end
   endtask

   task automatic test_load_priority();
      logic [7:0] a;
      drive_cycle(1'b0, 1'b1, 2);
      drive_cycle(1'b1, 1'b0, 0);
      // count is 1 in RUN: load must beat the terminal decrement
      drive_cycle(1'b1, 1'b1, 9);
      a = act_vec(); checks++;
      if (a !== exp_vec() || count !== 4'd9 || underflow !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL load_priority: actual=%b required=%b", a, exp_vec());
      end
      drive_cycle(1'b1, 1'b0, 0);
      a = act_vec(); checks++;
      if (a !== exp_vec()) begin
         failures++; $display("FAIL load_priority_next: actual=%b required=%b", a, exp_vec());
      end
   endtask

   task automatic test_zero_load();
      logic [7:0] a;
      drive_cycle(1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) begin
         a = act_vec(); checks++;
         if (a !== exp_vec() || a !== 8'b0000_1000) begin
            failures++; $display("FAIL zero_load[%0d]: actual=%b required=%b", i, a, exp_vec());
         end
         drive_cycle(1'b1, 1'b0, 0);
      end
   endtask

`ifdef COUNTDOWN4_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      logic [7:0] a;
      int ufs = 0;
      int dones = 0;
      drive_cycle(1'b0, 1'b1, 2);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, 1'b0, 0);
         if (underflow) ufs++;
         if (done) dones++;
         a = act_vec(); checks++;
         if (a !== exp_vec()) begin
            failures++; $display("FAIL auto_reload[%0d]: actual=%b required=%b", i, a, exp_vec());
         end
      end
      checks++;
      if (ufs != 3 || dones != 0) begin
         failures++; $display("FAIL auto_reload_pulses: actual ufs=%0d dones=%0d required ufs=3 dones=0", ufs, dones);
      end
   endtask
`endif

   task automatic test_random();
      logic [7:0] a;
      bit en, ld;
      int lv;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 9) == 0);
         lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
         drive_cycle(en, ld, lv);
         a = act_vec(); checks++;
         if (a !== exp_vec()) begin
            failures++; $display("FAIL random[%0d]: actual=%b required=%b", i, a, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_to_zero();
      test_enable_gating();
      test_load_priority();
      test_zero_load();
`ifdef COUNTDOWN4_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
